// File: rtl/spi_led_frame_tx.sv
// SPI master streaming one APA102-style frame (start word, pixel words, end words)
// per start request, followed by an externally timed inter-frame gap.
module spi_led_frame_tx #(
  parameter int NUM_LEDS   = 8,
  parameter int CLK_DIV    = 4,
  parameter int GAP_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  pix_addr,
  input  logic [31:0] pix_data,
  output logic        spi_sclk,
  output logic        spi_mosi,
  output logic        spi_cs_n,
  output logic        delay_en,
  output logic [31:0] delay_len,
  input  logic        delay_done,
  output logic        busy,
  output logic        frame_done
);

  localparam int END_CALC  = (NUM_LEDS + 63) / 64;
  localparam int END_WORDS = (END_CALC < 1) ? 1 : END_CALC;
  localparam int DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [7:0]       LAST_PIX = 8'(NUM_LEDS - 1);
  localparam logic [7:0]       LAST_END = 8'(END_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_PIXEL,
    ST_END,
    ST_GAP
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [7:0]       word_cnt;
  // Bits still to send after the one currently on spi_mosi.
  logic [30:0]      shreg;

  assign delay_len = GAP_CYCLES;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      shreg      <= '0;
      pix_addr   <= '0;
      spi_sclk   <= 1'b0;
      spi_mosi   <= 1'b0;
      spi_cs_n   <= 1'b1;
      delay_en   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          pix_addr <= '0;
          if (start) begin
            state    <= ST_START;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            spi_sclk <= 1'b0;
            spi_mosi <= 1'b0;
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
          end
        end

        ST_START, ST_PIXEL, ST_END: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_W'(1);
          end else begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt != 5'd31) begin
                bit_cnt  <= bit_cnt + 5'd1;
                spi_mosi <= shreg[30];
                shreg    <= {shreg[29:0], 1'b0};
              end else begin
                // Word boundary: end of the last high phase of the current word.
                bit_cnt <= '0;
                if (state == ST_START ||
                    (state == ST_PIXEL && word_cnt != LAST_PIX)) begin
                  spi_mosi <= pix_data[31];
                  shreg    <= pix_data[30:0];
                  if (pix_addr != LAST_PIX) pix_addr <= pix_addr + 8'd1;
                  word_cnt <= (state == ST_START) ? 8'd0 : word_cnt + 8'd1;
                  state    <= ST_PIXEL;
                end else if (state == ST_PIXEL ||
                             (state == ST_END && word_cnt != LAST_END)) begin
                  spi_mosi <= 1'b1;
                  shreg    <= '1;
                  word_cnt <= (state == ST_PIXEL) ? 8'd0 : word_cnt + 8'd1;
                  state    <= ST_END;
                end else begin
                  state    <= ST_GAP;
                  spi_cs_n <= 1'b1;
                  spi_mosi <= 1'b0;
                  delay_en <= 1'b1;
                  pix_addr <= '0;
                end
              end
            end
          end
        end

        ST_GAP: begin
          if (delay_done) begin
            state      <= ST_IDLE;
            delay_en   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_led_frame_tx.sv
// Bench for spi_led_frame_tx: frame table with random pixels, bit-level capture
// compared against the expected word sequence, plus reset/start corner sequences.
module tb_spi_led_frame_tx;

  localparam int N      = 2;
  localparam int CD     = 2;
  localparam int GAP    = 1000;
  localparam int E      = ((N + 63) / 64 < 1) ? 1 : (N + 63) / 64;
  localparam int NWORDS = 1 + N + E;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  pix_addr;
  logic [31:0] pix_data = '0;
  logic        spi_sclk, spi_mosi, spi_cs_n, delay_en, busy, frame_done;
  logic [31:0] delay_len;
  logic        delay_done = 1'b0;

  spi_led_frame_tx #(.NUM_LEDS(N), .CLK_DIV(CD), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start), .pix_addr(pix_addr),
    .pix_data(pix_data), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
    .spi_cs_n(spi_cs_n), .delay_en(delay_en), .delay_len(delay_len),
    .delay_done(delay_done), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Pixel buffer with one cycle of read latency.
  logic [31:0] mem [256];
  always @(posedge clk) pix_data <= mem[pix_addr];

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cap[$];
  int   cs_low_cnt = 0;
  int   fd_cnt = 0;
  int   pa_max = 0;
  logic prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (!spi_cs_n) cs_low_cnt = cs_low_cnt + 1;
    if (spi_sclk && !prev_sclk && !spi_cs_n) cap.push_back(spi_mosi);
    prev_sclk = spi_sclk;
    if (frame_done) fd_cnt = fd_cnt + 1;
    if (int'(pix_addr) > pa_max) pa_max = int'(pix_addr);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] p0, p1;
    int          gap;
    bit          mid, spur, dstart, chain, pre;
    int          exp_cs_low;
  } vec_t;

  vec_t tbl[6];

  task automatic prepare(input logic [31:0] p0, input logic [31:0] p1);
    mem[0] = p0;
    mem[1] = p1;
    cap.delete();
    cs_low_cnt = 0;
    pa_max = 0;
  endtask

  task automatic check_bits(input logic [31:0] p0, input logic [31:0] p1);
    logic [31:0] exp_w [NWORDS];
    logic [31:0] got;
    exp_w[0] = 32'h0;
    exp_w[1] = p0;
    exp_w[2] = p1;
    for (int w = 1 + N; w < NWORDS; w++) exp_w[w] = 32'hFFFF_FFFF;
    check("bit_count", cap.size(), 32 * NWORDS);
    if (cap.size() == 32 * NWORDS) begin
      for (int w = 0; w < NWORDS; w++) begin
        got = '0;
        for (int j = 0; j < 32; j++) got = {got[30:0], cap[32 * w + j]};
        check($sformatf("word%0d", w), got, exp_w[w]);
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input vec_t nxt);
    bit timeout;
    if (!v.pre) begin
      prepare(v.p0, v.p1);
      start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    check("cs_n_after_start", spi_cs_n, 0);
    check("busy_after_start", busy, 1);
    check("frame_done_low", frame_done, 0);
    check("start_bit_msb", spi_mosi, 0);
    repeat (CD - 1) @(negedge clk);
    check("sclk_low_phase", spi_sclk, 0);
    @(negedge clk);
    check("sclk_first_rise", spi_sclk, 1);

    timeout = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if (delay_en) begin
        timeout = 1'b0;
        break;
      end
      start      = v.mid && (k == 100);
      delay_done = v.spur && (k == 150);
      @(negedge clk);
    end
    start = 1'b0;
    delay_done = 1'b0;
    check("delay_en_timeout", timeout, 0);
    if (timeout) begin
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      return;
    end

    check("cs_low_cycles", cs_low_cnt, v.exp_cs_low);
    check("gap_cs_n", spi_cs_n, 1);
    check("gap_sclk", spi_sclk, 0);
    check("gap_mosi", spi_mosi, 0);
    check("gap_busy", busy, 1);
    check("delay_len", delay_len, GAP);
    check("gap_pix_addr", pix_addr, 0);
    check("pix_addr_max", pa_max, N - 1);
    check_bits(v.p0, v.p1);

    repeat (v.gap) @(negedge clk);
    check("gap_hold_delay_en", delay_en, 1);
    check("gap_hold_cs_n", spi_cs_n, 1);
    check("gap_hold_frame_done", frame_done, 0);

    delay_done = 1'b1;
    start = v.dstart;
    @(negedge clk);
    delay_done = 1'b0;
    start = 1'b0;
    check("frame_done_pulse", frame_done, 1);
    check("busy_at_done", busy, 0);
    check("delay_en_at_done", delay_en, 0);

    if (v.chain) begin
      prepare(nxt.p0, nxt.p1);
      start = 1'b1;
      return;
    end
    @(negedge clk);
    check("frame_done_once", frame_done, 0);
    if (v.dstart) begin
      check("dropped_start_cs_n", spi_cs_n, 1);
      check("dropped_start_busy", busy, 0);
    end
  endtask

  initial begin
    vec_t none;
    bit   timeout;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    tbl[0] = '{32'hE1FF_0000, 32'h1234_5678, 20, 0, 0, 0, 0, 0, 512};
    for (int i = 1; i < 6; i++)
      tbl[i] = '{$urandom, $urandom, int'($urandom_range(0, 40)), 0, 0, 0, 0, 0, 512};
    tbl[1].mid    = 1;
    tbl[2].spur   = 1;
    tbl[3].dstart = 1;
    tbl[4].chain  = 1;
    tbl[5].pre    = 1;
    none = tbl[0];

    repeat (3) @(negedge clk);
    check("rst_sclk", spi_sclk, 0);
    check("rst_mosi", spi_mosi, 0);
    check("rst_cs_n", spi_cs_n, 1);
    check("rst_delay_en", delay_en, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pix_addr", pix_addr, 0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_frame(tbl[i], (i < 5) ? tbl[i + 1] : none);

    // Reset partway through the pixel word, then a clean frame.
    prepare(32'hA5A5_5A5A, 32'h0F0F_F0F0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    timeout = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      if (cap.size() >= 40) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    check("bit40_timeout", timeout, 0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_cs_n", spi_cs_n, 1);
    check("midrst_sclk", spi_sclk, 0);
    check("midrst_mosi", spi_mosi, 0);
    check("midrst_delay_en", delay_en, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pix_addr", pix_addr, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", spi_cs_n, 1);
    run_frame('{32'hE3C0_FFEE, 32'hFF00_1122, 4, 0, 0, 0, 0, 0, 512}, none);

    check("frame_done_total", fd_cnt, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule
